// File: rtl/alu_ram_controller.sv
// Byte-addressed RAM behind the ALU req/ack memory handshake: one 32-bit
// little-endian word access per request, optional wait states, range check.
module alu_ram_controller #(
    parameter int RAMSIZE     = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readReq,
    input  logic        writeReq,
    input  logic [31:0] ramAddress,
    input  logic [31:0] ramIn,
    output logic [31:0] ramValue,
    output logic        readAck,
    output logic        writeAck,
    output logic        busy,
    output logic        addrError
);
    localparam int AW = $clog2(RAMSIZE);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_wr_q, is_wr_d;
    logic        rack_q, rack_d;
    logic        wack_q, wack_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [7:0]  mem [RAMSIZE];
    logic [31:0] mem_word;
    logic        in_range;

    assign in_range = addr_q < 32'(RAMSIZE);

    // Byte indices wrap modulo RAMSIZE, so a word straddling the top reads low bytes.
    always_comb begin
        mem_word = '0;
        for (int k = 0; k < 4; k++)
            mem_word[8*k +: 8] = mem[addr_q[AW-1:0] + AW'(k)];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        rack_d  = 1'b0;
        wack_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (readReq || writeReq) begin
                    addr_d  = ramAddress;
                    wdata_d = ramIn;
                    is_wr_d = writeReq;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = ACCESS;
            end
            ACCESS: begin
                rack_d = !is_wr_q;
                wack_d = is_wr_q;
                err_d  = !in_range;
                if (!is_wr_q)
                    rdata_d = in_range ? mem_word : 32'd0;
                state_d = RELEASE;
            end
            RELEASE: begin
                // Wait for the requester to drop both lines so a held request is not re-served.
                if (!readReq && !writeReq) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            rack_q  <= 1'b0;
            wack_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            rack_q  <= rack_d;
            wack_q  <= wack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == ACCESS && is_wr_q && in_range)
            for (int k = 0; k < 4; k++)
                mem[addr_q[AW-1:0] + AW'(k)] <= wdata_q[8*k +: 8];
    end

    assign ramValue  = rdata_q;
    assign readAck   = rack_q;
    assign writeAck  = wack_q;
    assign busy      = busy_q;
    assign addrError = err_q;
endmodule

// File: tb/tb_alu_ram_controller.sv
// Bench for alu_ram_controller: two instances (0 and 3 wait states) checked
// every cycle against a transaction-level model of memory and handshake timing.
module tb_alu_ram_controller;
    localparam int RS  = 256;
    localparam int INF = 32'h7fffffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        rreq [2];
    logic        wreq [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] rv   [2];
    logic        rack [2];
    logic        wack [2];
    logic        bsy  [2];
    logic        aerr [2];

    alu_ram_controller #(.RAMSIZE(RS), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(rst[0]), .readReq(rreq[0]), .writeReq(wreq[0]),
        .ramAddress(addr[0]), .ramIn(din[0]), .ramValue(rv[0]),
        .readAck(rack[0]), .writeAck(wack[0]), .busy(bsy[0]), .addrError(aerr[0]));

    alu_ram_controller #(.RAMSIZE(RS), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(rst[1]), .readReq(rreq[1]), .writeReq(wreq[1]),
        .ramAddress(addr[1]), .ramIn(din[1]), .ramValue(rv[1]),
        .readAck(rack[1]), .writeAck(wack[1]), .busy(bsy[1]), .addrError(aerr[1]));

    int wc [2] = '{0, 3};

    // model: memory image plus the expected timeline of the current transaction
    logic [7:0]  mm [2][RS];
    int          acc_c [2];
    int          ack_c [2];
    int          rel_c [2];
    bit          mw [2];
    bit          merr [2];
    bit          rst_hit [2];
    logic [31:0] pend [2];
    logic [31:0] cur [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int d, input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mm[d][8'(a + 32'(k))];
        return w;
    endfunction

    function automatic logic [31:0] pat(input int a);
        return {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) if (rst[d]) rst_hit[d] = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                if (rst_hit[d]) begin
                    cur[d] = 32'd0;
                    rst_hit[d] = 1'b0;
                end
                if (cyc == ack_c[d] && !mw[d]) cur[d] = pend[d];
                check("readAck",   d, 32'(rack[d]), 32'(cyc == ack_c[d] && !mw[d]));
                check("writeAck",  d, 32'(wack[d]), 32'(cyc == ack_c[d] && mw[d]));
                check("addrError", d, 32'(aerr[d]), 32'(cyc == ack_c[d] && merr[d]));
                check("busy",      d, 32'(bsy[d]),  32'(cyc >= acc_c[d] && cyc < rel_c[d]));
                check("ramValue",  d, rv[d], cur[d]);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the release edge.
    task automatic op(input int d, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] dat, input int hold);
        int n;
        n = cyc + 1;
        mw[d]   = w;
        merr[d] = (a >= 32'(RS));
        if (w) begin
            if (a < 32'(RS))
                for (int k = 0; k < 4; k++) mm[d][8'(a + 32'(k))] = dat[8*k +: 8];
        end else begin
            pend[d] = (a < 32'(RS)) ? word(d, a) : 32'd0;
        end
        acc_c[d] = n;
        ack_c[d] = n + 1 + wc[d];
        rel_c[d] = INF;
        rreq[d] = r; wreq[d] = w; addr[d] = a; din[d] = dat;
        @(negedge clk);
        addr[d] = $urandom; din[d] = $urandom;
        while (cyc < ack_c[d] + hold) @(negedge clk);
        rel_c[d] = cyc + 1;
        rreq[d] = 1'b0; wreq[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic rnd(input int d, input int cnt);
        int k;
        logic [31:0] a;
        for (int i = 0; i < cnt; i++) begin
            k = $urandom_range(0, 2);
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, RS - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op(d, k != 1, k != 0, a, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rreq[d] = 1'b0; wreq[d] = 1'b0; addr[d] = '0; din[d] = '0;
            acc_c[d] = INF; ack_c[d] = INF; rel_c[d] = INF; mw[d] = 1'b0; merr[d] = 1'b0;
            pend[d] = '0; cur[d] = '0; rst_hit[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ramValue", 0, rv[0], 32'd0);
        check("reset_busy", 1, 32'(bsy[1]), 32'd0);

        // give every byte a known value: mem[i] = i
        fork
            for (int a = 0; a < RS; a += 4) op(0, 1'b1, 1'b0, 32'(a), pat(a), 0);
            for (int a = 0; a < RS; a += 4) op(1, 1'b1, 1'b0, 32'(a), pat(a), 0);
        join

        op(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        op(0, 1'b0, 1'b1, 32'h10, 32'h0, 0);
        check("rd_deadbeef", 0, rv[0], 32'hDEADBEEF);
        check("model_byte10", 0, 32'(mm[0][16]), 32'hEF);

        op(0, 1'b1, 1'b0, 32'hFE, 32'h11223344, 0);
        op(0, 1'b0, 1'b1, 32'hFE, 32'h0, 0);
        check("rd_wrap", 0, rv[0], 32'h11223344);
        check("model_byte00", 0, 32'(mm[0][0]), 32'h22);
        check("model_byteFF", 0, 32'(mm[0][255]), 32'h33);

        op(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 5);
        check("both_rv_kept", 0, rv[0], 32'h11223344);
        check("model_byte20", 0, 32'(mm[0][32]), 32'hA5);

        op(0, 1'b0, 1'b1, 32'h100, 32'h0, 0);
        check("rd_oor_zero", 0, rv[0], 32'd0);
        op(0, 1'b1, 1'b0, 32'h100, 32'h12345678, 0);
        op(0, 1'b0, 1'b1, 32'h0, 32'h0, 0);
        check("rd_after_oor_wr", 0, rv[0], 32'h03021122);

        // reset during WAIT discards the write
        n = cyc + 1;
        acc_c[1] = n; ack_c[1] = INF; rel_c[1] = INF;
        wreq[1] = 1'b1; addr[1] = 32'h40; din[1] = 32'hCAFEF00D;
        @(negedge clk);
        wreq[1] = 1'b0; rst[1] = 1'b1; rel_c[1] = n + 1;
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (5) @(negedge clk);
        op(1, 1'b0, 1'b1, 32'h40, 32'h0, 0);
        check("abort_mem_kept", 1, rv[1], 32'h43424140);

        fork
            rnd(0, 80);
            rnd(1, 80);
        join

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
